// File: rtl/vga_frame_sequencer.sv
// VGA raster timing and line-renderer scheduling for the wirecube design.
// Generates syncs, blanking, gated colour and a per-line prefetch request.
module vga_frame_sequencer #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned PREFETCH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [5:0] rgb_in,
  input  logic       line_ack,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [5:0] rrggbb,
  output logic       frame_start,
  output logic       line_req,
  output logic [9:0] line_num,
  output logic       underrun,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HAct    = 10'(H_ACTIVE);
  localparam logic [9:0] VAct    = 10'(V_ACTIVE);
  localparam logic [9:0] HsStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VsStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] ReqH    = 10'(H_TOTAL - PREFETCH);

  typedef enum logic {StIdle, StReq} state_t;
  state_t state;

  logic       h_last, v_last, disp, hs_on, vs_on, req_start, abort, fs_next;
  logic [9:0] next_v;

  always_comb begin
    h_last    = (hpos == HLast);
    v_last    = (vpos == VLast);
    next_v    = v_last ? 10'd0 : vpos + 10'd1;
    disp      = (hpos < HAct) && (vpos < VAct);
    hs_on     = (hpos >= HsStart) && (hpos < HsEnd);
    vs_on     = (vpos >= VsStart) && (vpos < VsEnd);
    req_start = (hpos == ReqH) && (next_v < VAct);
    // Renderer missed its slot: the raster is about to enter the requested line.
    abort     = (state == StReq) && !line_ack && h_last && (next_v == line_num);
    fs_next   = (hpos == 10'd0) && (vpos == 10'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      display_on  <= 1'b0;
      rrggbb      <= '0;
      frame_start <= 1'b0;
      line_req    <= 1'b0;
      line_num    <= '0;
      underrun    <= 1'b0;
      frame_count <= '0;
      state       <= StIdle;
    end else if (ena) begin
      hpos <= h_last ? 10'd0 : hpos + 10'd1;
      if (h_last) begin
        vpos <= next_v;
        if (v_last) frame_count <= frame_count + 8'd1;
      end

      display_on  <= disp;
      hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
      rrggbb      <= disp ? rgb_in : 6'd0;
      frame_start <= fs_next;

      // Set has priority over the frame-start clear.
      if (abort)        underrun <= 1'b1;
      else if (fs_next) underrun <= 1'b0;

      unique case (state)
        StIdle: begin
          if (req_start) begin
            line_req <= 1'b1;
            line_num <= next_v;
            state    <= StReq;
          end
        end
        StReq: begin
          if (line_ack || abort) begin
            line_req <= 1'b0;
            state    <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Directed bench for vga_frame_sequencer on a shrunken raster (25 x 13) so
// full frames stay short; expectations derive from the bench's own timing constants.
module tb_vga_frame_sequencer;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int PF = 5;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic       clk, rst, ena, line_ack;
  logic [5:0] rgb_in;
  logic [9:0] hpos, vpos, line_num;
  logic       hsync, vsync, display_on, frame_start, line_req, underrun;
  logic [5:0] rrggbb;
  logic [7:0] frame_count;

  logic       ack_en, ack_wrap;
  logic [9:0] ack_block;

  int checks = 0;
  int failures = 0;

  // Ack generator: optionally refuse one line, optionally ack only on the wrap clock.
  assign line_ack = ack_en && !(line_req && line_num == ack_block) &&
                    (!ack_wrap || hpos == 10'(HT - 1));

  vga_frame_sequencer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .PREFETCH(PF)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .rgb_in(rgb_in), .line_ack(line_ack),
    .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .rrggbb(rrggbb), .frame_start(frame_start), .line_req(line_req), .line_num(line_num),
    .underrun(underrun), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h, v, ph, pv, nv;
    int vid_err, req_err, hs_lo, vs_lo, req_cnt, fs_cnt, ur_cnt;
    logic exp_disp, exp_hs, exp_vs, exp_req;

    clk = 0; rst = 1; ena = 1; rgb_in = 6'h3F;
    ack_en = 1; ack_wrap = 0; ack_block = 10'h3FF;
    #2;
    check("rst_hpos", hpos, 0);
    check("rst_vpos", vpos, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_disp", display_on, 0);
    check("rst_rgb", rrggbb, 0);
    check("rst_req", line_req, 0);
    check("rst_fs", frame_start, 0);
    check("rst_fc", frame_count, 0);
    #2 rst = 0;

    // Two free-running frames with ack tied high.
    vid_err = 0; req_err = 0; hs_lo = 0; vs_lo = 0; req_cnt = 0; fs_cnt = 0; ur_cnt = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      tick();
      if (i == 0) begin
        check("first_hpos", hpos, 1);
        check("first_fs", frame_start, 1);
        check("first_disp", display_on, 1);
        check("first_rgb", rrggbb, 6'h3F);
      end
      h  = int'(hpos);
      v  = int'(vpos);
      ph = (h == 0) ? HT - 1 : h - 1;
      pv = (h == 0) ? ((v == 0) ? VT - 1 : v - 1) : v;
      exp_disp = (ph < HA) && (pv < VA);
      exp_hs   = !((ph >= HA + HF) && (ph < HA + HF + HS));
      exp_vs   = !((pv >= VA + VF) && (pv < VA + VF + VS));
      if (display_on !== exp_disp || hsync !== exp_hs || vsync !== exp_vs ||
          rrggbb !== (exp_disp ? 6'h3F : 6'h00)) vid_err++;
      nv = (v + 1) % VT;
      exp_req = (h == HT - PF + 1) && (nv < VA);
      if (line_req !== exp_req || (exp_req && int'(line_num) != nv)) req_err++;
      if (hsync === 1'b0) hs_lo++;
      if (vsync === 1'b0) vs_lo++;
      if (line_req === 1'b1) req_cnt++;
      if (frame_start === 1'b1) fs_cnt++;
      if (underrun !== 1'b0) ur_cnt++;
    end
    check("run_video_err", vid_err, 0);
    check("run_req_err", req_err, 0);
    check("run_hsync_low", hs_lo, 2 * VT * HS);
    check("run_vsync_low", vs_lo, 2 * VS * HT);
    check("run_req_cnt", req_cnt, 2 * VA);
    check("run_fs_cnt", fs_cnt, 2);
    check("run_underrun", ur_cnt, 0);
    check("run_fc", frame_count, 2);
    check("run_end_hpos", hpos, 0);
    check("run_end_vpos", vpos, 0);

    // Withhold ack for line 5.
    ack_block = 10'd5;
    repeat (5 * HT - 1) tick();
    check("ur_pre_hpos", hpos, HT - 1);
    check("ur_pre_vpos", vpos, 4);
    check("ur_pre_req", line_req, 1);
    check("ur_pre_num", line_num, 5);
    check("ur_pre_flag", underrun, 0);
    tick();
    check("ur_wrap_vpos", vpos, 5);
    check("ur_wrap_req", line_req, 0);
    check("ur_wrap_flag", underrun, 1);
    repeat ((VT - 5) * HT) tick();
    check("ur_hold_flag", underrun, 1);
    check("ur_hold_vpos", vpos, 0);
    check("ur_hold_fs", frame_start, 0);
    tick();
    check("ur_clr_fs", frame_start, 1);
    check("ur_clr_flag", underrun, 0);

    // Ack only on the wrap clock: ack must win over the abort.
    ack_block = 10'h3FF;
    ack_wrap = 1;
    ur_cnt = 0; req_cnt = 0;
    repeat (HT * VT) begin
      tick();
      if (underrun !== 1'b0) ur_cnt++;
      if (line_req === 1'b1) req_cnt++;
    end
    check("wack_underrun", ur_cnt, 0);
    check("wack_req_cnt", req_cnt, VA * (PF - 1));

    // Freeze while a request is pending.
    repeat (21) tick();
    check("frz_pre_hpos", hpos, 22);
    check("frz_pre_req", line_req, 1);
    ena = 0; rgb_in = 6'h00; ack_wrap = 0;
    repeat (100) tick();
    check("frz_hpos", hpos, 22);
    check("frz_vpos", vpos, 0);
    check("frz_req", line_req, 1);
    check("frz_hsync", hsync, 0);
    check("frz_rgb", rrggbb, 0);
    check("frz_fc", frame_count, 4);
    ena = 1; ack_wrap = 1; rgb_in = 6'h3F;
    tick();
    check("frz_resume_hpos", hpos, 23);
    check("frz_resume_req", line_req, 1);

    // Asynchronous reset between edges while line_req is high.
    #3 rst = 1;
    #1;
    check("arst_hpos", hpos, 0);
    check("arst_vpos", vpos, 0);
    check("arst_req", line_req, 0);
    check("arst_num", line_num, 0);
    check("arst_hsync", hsync, 1);
    check("arst_vsync", vsync, 1);
    check("arst_fc", frame_count, 0);
    check("arst_ur", underrun, 0);
    #2 rst = 0;
    ack_wrap = 0;
    tick();
    check("post_hpos1", hpos, 1);
    check("post_fs", frame_start, 1);
    tick();
    check("post_hpos2", hpos, 2);
    repeat (HT - PF - 1) tick();
    check("post_req_hpos", hpos, HT - PF + 1);
    check("post_req_vpos", vpos, 0);
    check("post_req", line_req, 1);
    check("post_req_num", line_num, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
